// File: rtl/hash_op_master.sv
// hash_op_master: sequences one hash table op at a time from a request stream to a response stream
module hash_op_master #(
    parameter int KEY_WIDTH      = 32,
    parameter int VALUE_WIDTH    = 32,
    parameter int CHAINING_SIZE  = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH      = 16,
    localparam int CW            = $clog2(CHAINING_SIZE)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [KEY_WIDTH-1:0]   req_key,
    input  logic [VALUE_WIDTH-1:0] req_value,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [1:0]             rsp_status,
    output logic [VALUE_WIDTH-1:0] rsp_value,
    output logic [CW-1:0]          rsp_collision,
    output logic [KEY_WIDTH-1:0]   ht_key,
    output logic [VALUE_WIDTH-1:0] ht_value,
    output logic [1:0]             ht_op_sel,
    output logic                   ht_op_en,
    input  logic [VALUE_WIDTH-1:0] ht_value_out,
    input  logic                   ht_op_done,
    input  logic                   ht_op_error,
    input  logic [CW-1:0]          ht_collision,
    output logic [CNT_WIDTH-1:0]   op_count,
    output logic [CNT_WIDTH-1:0]   err_count
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                 state, next;
    logic [1:0]             lat_op;
    logic [KEY_WIDTH-1:0]   lat_key;
    logic [VALUE_WIDTH-1:0] lat_value;
    logic [TW-1:0]          timer;
    logic                   timeout_hit, busy;

    assign timeout_hit = timer == TW'(TIMEOUT_CYCLES - 1);
    assign busy        = state == ISSUE || state == WAIT;
    assign req_ready   = state == IDLE;
    assign rsp_valid   = state == RESP;
    assign ht_op_en    = state == ISSUE;
    assign ht_key      = busy ? lat_key : '0;
    assign ht_value    = busy ? lat_value : '0;
    assign ht_op_sel   = busy ? lat_op : '0;

    // State register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= next;

    // Next-state: illegal ops skip the table, done beats timeout in WAIT
    always_comb begin
        next = state;
        unique case (state)
            IDLE:  if (req_valid) next = req_op == 2'b11 ? RESP : ISSUE;
            ISSUE: next = WAIT;
            WAIT:  if (ht_op_done || timeout_hit) next = RESP;
            RESP:  if (rsp_ready) next = IDLE;
        endcase
    end

    // Request latch, wait timer, response capture and saturating statistics
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            lat_op        <= '0;
            lat_key       <= '0;
            lat_value     <= '0;
            timer         <= '0;
            rsp_status    <= '0;
            rsp_value     <= '0;
            rsp_collision <= '0;
            op_count      <= '0;
            err_count     <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                lat_op     <= req_op;
                lat_key    <= req_key;
                lat_value  <= req_value;
                if (req_op == 2'b11) rsp_status <= 2'b11;
            end
            if (state == ISSUE) timer <= '0;
            if (state == WAIT) begin
                if (ht_op_done) begin
                    rsp_status    <= {1'b0, ht_op_error};
                    rsp_collision <= ht_collision;
                    rsp_value     <= (lat_op == 2'b10 && !ht_op_error) ? ht_value_out : '0;
                end else if (timeout_hit) rsp_status <= 2'b10;
                else timer <= timer + TW'(1);
            end
            if (state == RESP && rsp_ready) begin
                rsp_status    <= '0;
                rsp_value     <= '0;
                rsp_collision <= '0;
                op_count      <= op_count + CNT_WIDTH'(op_count != '1);
                err_count     <= err_count + CNT_WIDTH'(rsp_status != 2'b00 && err_count != '1);
            end
        end
endmodule

// File: tb/tb_hash_op_master.sv
// tb_hash_op_master: directed table-driven checks of the hash op sequencer
module tb_hash_op_master;
    logic       clk = 0, rst = 1;
    logic       req_valid = 0, req_ready;
    logic [1:0] req_op = 0;
    logic [7:0] req_key = 0, req_value = 0;
    logic       rsp_valid, rsp_ready = 0;
    logic [1:0] rsp_status;
    logic [7:0] rsp_value;
    logic [1:0] rsp_collision;
    logic [7:0] ht_key, ht_value;
    logic [1:0] ht_op_sel;
    logic       ht_op_en;
    logic [7:0] ht_value_out = 0;
    logic       ht_op_done = 0, ht_op_error = 0;
    logic [1:0] ht_collision = 0;
    logic [1:0] op_count, err_count;

    int n_checks = 0, n_fail = 0;
    int exp_ops = 0, exp_errs = 0;

    hash_op_master #(.KEY_WIDTH(8), .VALUE_WIDTH(8), .CHAINING_SIZE(4),
                     .TIMEOUT_CYCLES(8), .CNT_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_key(req_key), .req_value(req_value),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .rsp_value(rsp_value), .rsp_collision(rsp_collision),
        .ht_key(ht_key), .ht_value(ht_value), .ht_op_sel(ht_op_sel), .ht_op_en(ht_op_en),
        .ht_value_out(ht_value_out), .ht_op_done(ht_op_done), .ht_op_error(ht_op_error),
        .ht_collision(ht_collision), .op_count(op_count), .err_count(err_count));

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [7:0] key, value;
        int         delay;
        logic       err;
        logic [7:0] vout;
        logic [1:0] coll;
        logic [1:0] e_status;
        logic [7:0] e_value;
        logic [1:0] e_coll;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic finish_rsp(input logic [1:0] st);
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        if (exp_ops != 3) exp_ops++;
        if (st != 2'b00 && exp_errs != 3) exp_errs++;
        chk("op_count", op_count, exp_ops);
        chk("err_count", err_count, exp_errs);
        chk("req_ready_after", req_ready, 1);
        chk("rsp_valid_after", rsp_valid, 0);
    endtask

    task automatic run_vec(input vec_t v);
        req_valid = 1; req_op = v.op; req_key = v.key; req_value = v.value;
        @(negedge clk);
        req_valid = 0;
        chk("issue_en", ht_op_en, 1);
        chk("issue_sel", ht_op_sel, v.op);
        chk("issue_key", ht_key, v.key);
        chk("issue_value", ht_value, v.value);
        chk("issue_ready", req_ready, 0);
        for (int j = 1; j <= v.delay; j++) begin
            @(negedge clk);
            chk("wait_en", ht_op_en, 0);
            chk("wait_sel", ht_op_sel, v.op);
            chk("wait_key", ht_key, v.key);
            chk("wait_rsp_valid", rsp_valid, 0);
            if (j == v.delay) begin
                ht_op_done = 1; ht_op_error = v.err; ht_value_out = v.vout; ht_collision = v.coll;
            end
        end
        @(negedge clk);
        ht_op_done = 0; ht_op_error = 0; ht_value_out = 8'hEE; ht_collision = 0;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_status", rsp_status, v.e_status);
        chk("rsp_value", rsp_value, v.e_value);
        chk("rsp_collision", rsp_collision, v.e_coll);
        chk("resp_key_zero", ht_key, 0);
        chk("resp_ready", req_ready, 0);
        finish_rsp(v.e_status);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{2'b00, 8'h05, 8'hAA, 2, 1'b0, 8'h33, 2'd0, 2'b00, 8'h00, 2'd0};
        vecs[1] = '{2'b10, 8'h05, 8'h00, 2, 1'b0, 8'hAA, 2'd1, 2'b00, 8'hAA, 2'd1};
        vecs[2] = '{2'b01, 8'h45, 8'h00, 1, 1'b1, 8'h77, 2'd2, 2'b01, 8'h00, 2'd2};
        vecs[3] = '{2'b10, 8'h09, 8'h00, 3, 1'b1, 8'h55, 2'd3, 2'b01, 8'h00, 2'd3};
        vecs[4] = '{2'b00, 8'h33, 8'h44, 1, 1'b0, 8'h11, 2'd2, 2'b00, 8'h00, 2'd2};
        vecs[5] = '{2'b01, 8'h66, 8'h00, 5, 1'b1, 8'h00, 2'd0, 2'b01, 8'h00, 2'd0};
        repeat (2) @(negedge clk);
        chk("rst_en", ht_op_en, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_op_count", op_count, 0);
        rst = 0;
        @(negedge clk);
        chk("idle_ready", req_ready, 1);
        chk("idle_key", ht_key, 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        req_valid = 1; req_op = 2'b10; req_key = 8'h12;
        @(negedge clk);
        req_valid = 0;
        chk("to_issue_en", ht_op_en, 1);
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            chk("to_wait_rsp_valid", rsp_valid, 0);
        end
        @(negedge clk);
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_status", rsp_status, 2'b10);
        chk("to_value", rsp_value, 0);
        ht_op_done = 1; ht_op_error = 1; ht_value_out = 8'h99; ht_collision = 3;
        @(negedge clk);
        ht_op_done = 0; ht_op_error = 0; ht_collision = 0;
        chk("to_late_status", rsp_status, 2'b10);
        chk("to_late_value", rsp_value, 0);
        chk("to_late_coll", rsp_collision, 0);
        finish_rsp(2'b10);

        req_valid = 1; req_op = 2'b11; req_key = 8'h7F;
        @(negedge clk);
        req_valid = 0;
        chk("ill_en", ht_op_en, 0);
        chk("ill_rsp_valid", rsp_valid, 1);
        chk("ill_status", rsp_status, 2'b11);
        repeat (5) begin
            @(negedge clk);
            chk("ill_stall_valid", rsp_valid, 1);
            chk("ill_stall_status", rsp_status, 2'b11);
            chk("ill_stall_ready", req_ready, 0);
            chk("ill_stall_en", ht_op_en, 0);
        end
        finish_rsp(2'b11);
        chk("err_saturated", err_count, 3);

        ht_op_done = 1;
        @(negedge clk);
        ht_op_done = 0;
        chk("idle_done_ready", req_ready, 1);
        chk("idle_done_rsp", rsp_valid, 0);

        req_valid = 1; req_op = 2'b01; req_key = 8'h21; req_value = 8'h42;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        chk("pre_rst_sel", ht_op_sel, 2'b01);
        chk("pre_rst_key", ht_key, 8'h21);
        rst = 1;
        @(negedge clk);
        chk("mid_rst_en", ht_op_en, 0);
        chk("mid_rst_key", ht_key, 0);
        chk("mid_rst_sel", ht_op_sel, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_op_count", op_count, 0);
        chk("mid_rst_err_count", err_count, 0);
        rst = 0;
        exp_ops = 0; exp_errs = 0;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 1);
        run_vec(vecs[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
